// File: rtl/jpeg_pr_cfg_sequencer.sv
// AXI4-Lite master that writes a bank of NUM_REGS configuration words into the
// JPEG_PR slave, reads each one back and compares it with the value written.
// Reports completion, a sticky error flag, the failing register index and the
// failure cause (bus error response, readback mismatch or handshake timeout).
module jpeg_pr_cfg_sequencer #(
  parameter int                    NUM_REGS   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    TIMEOUT    = 1023
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           start,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_data,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     err_code,
  output logic [$clog2(NUM_REGS):0]      err_index,
  output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                     M_AXI_AWPROT,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                     M_AXI_ARPROT,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY
);

  localparam int IDX_W = $clog2(NUM_REGS) + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] CODE_RESP     = 2'b01;
  localparam logic [1:0] CODE_MISMATCH = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD,
    S_NEXT,
    S_FAIL,
    S_DONE
  } state_t;

  state_t                         state_reg, state_next;
  logic [IDX_W-1:0]               idx_reg, idx_next;
  logic                           aw_done_reg, aw_done_next;
  logic                           w_done_reg, w_done_next;
  logic [TMR_W-1:0]               timer_reg, timer_next;
  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_reg;
  logic                           error_reg;
  logic [1:0]                     err_code_reg;
  logic [IDX_W-1:0]               err_index_reg;

  logic                           capture;
  logic [1:0]                     fail_code;
  logic [DATA_WIDTH-1:0]          word_cur;
  logic [ADDR_WIDTH-1:0]          addr_cur;
  logic                           aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic                           in_wait, tmr_hit;

  // Channel handshakes; VALID/READY outputs depend only on registered state.
  assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs   = M_AXI_BREADY  & M_AXI_BVALID;
  assign ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs   = M_AXI_RREADY  & M_AXI_RVALID;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign in_wait = (state_reg == S_WR) || (state_reg == S_WB) ||
                   (state_reg == S_RA) || (state_reg == S_RD);
  assign tmr_hit = (timer_reg == TMR_LIMIT);

  assign addr_cur = BASE_ADDR + (ADDR_WIDTH'(idx_reg) << 2);

  // Select the captured word for the current register index.
  always_comb begin
    word_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        word_cur = cfg_reg[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic of the write / readback sequencer.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    aw_done_next = 1'b0;
    w_done_next  = 1'b0;
    capture      = 1'b0;
    fail_code    = 2'b00;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = S_WR;
        end
      end
      S_WR: begin
        // Address and data channels complete independently; move on only
        // once both acceptances have been registered.
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg  | w_hs;
        if (aw_done_reg && w_done_reg) begin
          state_next = S_WB;
        end else if (tmr_hit && !aw_hs && !w_hs) begin
          state_next = S_FAIL;
          fail_code  = CODE_TIMEOUT;
        end
      end
      S_WB: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            state_next = S_FAIL;
            fail_code  = CODE_RESP;
          end else begin
            state_next = S_RA;
          end
        end else if (tmr_hit) begin
          state_next = S_FAIL;
          fail_code  = CODE_TIMEOUT;
        end
      end
      S_RA: begin
        if (M_AXI_ARREADY) begin
          state_next = S_RD;
        end else if (tmr_hit) begin
          state_next = S_FAIL;
          fail_code  = CODE_TIMEOUT;
        end
      end
      S_RD: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            state_next = S_FAIL;
            fail_code  = CODE_RESP;
          end else if (M_AXI_RDATA != word_cur) begin
            state_next = S_FAIL;
            fail_code  = CODE_MISMATCH;
          end else begin
            state_next = S_NEXT;
          end
        end else if (tmr_hit) begin
          state_next = S_FAIL;
          fail_code  = CODE_TIMEOUT;
        end
      end
      S_NEXT: begin
        if (idx_reg == LAST_IDX) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = S_WR;
        end
      end
      S_FAIL:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake watchdog: restarts on state changes and on any handshake.
  always_comb begin
    timer_next = '0;
    if ((state_next == state_reg) && !any_hs && in_wait) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  // State, index, channel tracking and watchdog registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      timer_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      timer_reg   <= timer_next;
    end
  end

  // Configuration words are frozen when a start is accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cfg_reg <= '0;
    end else if (capture) begin
      cfg_reg <= cfg_data;
    end
  end

  // Sticky status: cleared by an accepted start, loaded on entry to FAIL.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      error_reg     <= 1'b0;
      err_code_reg  <= 2'b00;
      err_index_reg <= '0;
    end else if (capture) begin
      error_reg     <= 1'b0;
      err_code_reg  <= 2'b00;
      err_index_reg <= '0;
    end else if ((state_next == S_FAIL) && (state_reg != S_FAIL)) begin
      error_reg     <= 1'b1;
      err_code_reg  <= fail_code;
      err_index_reg <= idx_reg;
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign error     = error_reg;
  assign err_code  = err_code_reg;
  assign err_index = err_index_reg;

  assign M_AXI_AWADDR  = addr_cur;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (state_reg == S_WR) && !aw_done_reg;
  assign M_AXI_WDATA   = word_cur;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = (state_reg == S_WR) && !w_done_reg;
  assign M_AXI_BREADY  = (state_reg == S_WB);
  assign M_AXI_ARADDR  = addr_cur;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_reg == S_RA);
  assign M_AXI_RREADY  = (state_reg == S_RD);

endmodule

// File: tb/tb_jpeg_pr_cfg_sequencer.sv
// Bench for jpeg_pr_cfg_sequencer: a behavioural AXI4-Lite slave with
// injectable faults, a scoreboard of expected bus transactions and done
// reports, and a monitor that pops and compares as the DUT produces them.
module tb_jpeg_pr_cfg_sequencer;

  logic         tb_ACLK = 1'b0;
  logic         ARESET;
  logic         start;
  logic [127:0] cfg_data;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic [2:0]   err_index;
  logic [31:0]  M_AXI_AWADDR;
  logic [2:0]   M_AXI_AWPROT;
  logic         M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0]  M_AXI_WDATA;
  logic [3:0]   M_AXI_WSTRB;
  logic         M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]   M_AXI_BRESP;
  logic         M_AXI_BVALID, M_AXI_BREADY;
  logic [31:0]  M_AXI_ARADDR;
  logic [2:0]   M_AXI_ARPROT;
  logic         M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0]  M_AXI_RDATA;
  logic [1:0]   M_AXI_RRESP;
  logic         M_AXI_RVALID, M_AXI_RREADY;

  jpeg_pr_cfg_sequencer #(
    .NUM_REGS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .TIMEOUT(1023)
  ) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int cyc = 0;
  always @(posedge tb_ACLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  // kind: 1 write (addr,data), 2 read (addr), 3 done (err,code,idx,latency)
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
    logic [2:0]  idx;
    int          lat;
  } ev_t;

  ev_t exp_q[$];

  // ---------------- slave model ----------------
  int          slv_aw_wait = 0;
  logic        slv_ar_block = 1'b0;
  logic        slv_bresp_en = 1'b0;
  logic [31:0] slv_bresp_addr = 32'h0;
  logic        slv_bad_en = 1'b0;
  logic [31:0] slv_bad_addr = 32'h0;
  logic [31:0] slv_bad_val = 32'h0;
  logic [31:0] mem [16];

  initial begin
    logic s_aw, s_w, s_b, s_ar, s_r, aw_got, w_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr, aw_a, w_d;
    aw_got = 1'b0; w_got = 1'b0; aw_a = '0; w_d = '0;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_ARREADY = 1'b1;
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge tb_ACLK);
      s_aw = M_AXI_AWVALID && M_AXI_AWREADY; s_awaddr = M_AXI_AWADDR;
      s_w  = M_AXI_WVALID && M_AXI_WREADY;   s_wdata  = M_AXI_WDATA;
      s_b  = M_AXI_BVALID && M_AXI_BREADY;
      s_ar = M_AXI_ARVALID && M_AXI_ARREADY; s_araddr = M_AXI_ARADDR;
      s_r  = M_AXI_RVALID && M_AXI_RREADY;
      if (ARESET) begin aw_got = 1'b0; w_got = 1'b0; end
      @(posedge tb_ACLK);
      #1;
      if (s_b) M_AXI_BVALID = 1'b0;
      if (s_r) M_AXI_RVALID = 1'b0;
      if (s_aw) begin aw_got = 1'b1; aw_a = s_awaddr; end
      if (s_w)  begin w_got = 1'b1;  w_d = s_wdata; end
      if (aw_got && w_got && !M_AXI_BVALID) begin
        mem[aw_a[5:2]] = w_d;
        M_AXI_BRESP  = (slv_bresp_en && aw_a == slv_bresp_addr) ? 2'b10 : 2'b00;
        M_AXI_BVALID = 1'b1;
        aw_got = 1'b0; w_got = 1'b0;
      end
      if (s_ar) begin
        M_AXI_RDATA  = (slv_bad_en && s_araddr == slv_bad_addr) ? slv_bad_val : mem[s_araddr[5:2]];
        M_AXI_RRESP  = 2'b00;
        M_AXI_RVALID = 1'b1;
      end
      if (M_AXI_AWVALID && slv_aw_wait > 0) begin
        M_AXI_AWREADY = 1'b0;
        slv_aw_wait   = slv_aw_wait - 1;
      end else begin
        M_AXI_AWREADY = 1'b1;
      end
      M_AXI_WREADY  = 1'b1;
      M_AXI_ARREADY = !slv_ar_block;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic void compare_ev(input ev_t g);
    ev_t e;
    logic bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_txn: got kind=%0d addr=%h data=%h err=%0b code=%0b idx=%0d lat=%0d, required none",
               g.kind, g.addr, g.data, g.err, g.code, g.idx, g.lat);
      return;
    end
    e = exp_q.pop_front();
    bad = (g.kind != e.kind);
    if (!bad && e.kind == 1) bad = (g.addr != e.addr) || (g.data != e.data);
    if (!bad && e.kind == 2) bad = (g.addr != e.addr);
    if (!bad && e.kind == 3) bad = (g.err != e.err) || (g.code != e.code) || (g.idx != e.idx) ||
                                   (e.lat >= 0 && g.lat != e.lat);
    if (bad) begin
      errors++;
      $display("FAIL txn_kind%0d: got addr=%h data=%h err=%0b code=%0b idx=%0d lat=%0d, required kind=%0d addr=%h data=%h err=%0b code=%0b idx=%0d lat=%0d",
               g.kind, g.addr, g.data, g.err, g.code, g.idx, g.lat,
               e.kind, e.addr, e.data, e.err, e.code, e.idx, e.lat);
    end else begin
      $display("txn ok kind=%0d addr=%h data=%h err=%0b code=%0b idx=%0d lat=%0d",
               g.kind, g.addr, g.data, g.err, g.code, g.idx, g.lat);
    end
  endfunction

  logic        m_aw_have = 1'b0, m_w_have = 1'b0;
  logic [31:0] m_aw = '0, m_wd = '0;

  always @(negedge tb_ACLK) begin
    ev_t g;
    if (ARESET) begin
      m_aw_have = 1'b0;
      m_w_have  = 1'b0;
    end else begin
      g = '{kind: 0, addr: '0, data: '0, err: 1'b0, code: 2'b00, idx: 3'd0, lat: 0};
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin m_aw_have = 1'b1; m_aw = M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY)   begin m_w_have = 1'b1;  m_wd = M_AXI_WDATA; end
      if (m_aw_have && m_w_have) begin
        g.kind = 1; g.addr = m_aw; g.data = m_wd;
        compare_ev(g);
        m_aw_have = 1'b0; m_w_have = 1'b0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        g.kind = 2; g.addr = M_AXI_ARADDR; g.data = '0;
        compare_ev(g);
      end
      if (done) begin
        g.kind = 3; g.addr = '0; g.data = '0;
        g.err = error; g.code = err_code; g.idx = err_index; g.lat = cyc - start_cyc + 1;
        compare_ev(g);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{kind: 1, addr: a, data: d, err: 1'b0, code: 2'b00, idx: 3'd0, lat: 0});
  endtask

  task automatic push_r(input logic [31:0] a);
    exp_q.push_back('{kind: 2, addr: a, data: '0, err: 1'b0, code: 2'b00, idx: 3'd0, lat: 0});
  endtask

  task automatic push_d(input logic e, input logic [1:0] c, input logic [2:0] i, input int l);
    exp_q.push_back('{kind: 3, addr: '0, data: '0, err: e, code: c, idx: i, lat: l});
  endtask

  task automatic push_pass(input logic [127:0] c, input int l);
    for (int i = 0; i < 4; i++) begin
      push_w(32'(i * 4), c[i*32 +: 32]);
      push_r(32'(i * 4));
    end
    push_d(1'b0, 2'b00, 3'd0, l);
  endtask

  task automatic do_start(input logic [127:0] c);
    @(posedge tb_ACLK); #1;
    start = 1'b1; cfg_data = c;
    @(posedge tb_ACLK); #1;
    start = 1'b0; start_cyc = cyc;
  endtask

  task automatic pulse_start(input logic [127:0] c);
    #1 start = 1'b1; cfg_data = c;
    @(posedge tb_ACLK); #1;
    start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("check ok %s = %h", name, got);
    end
  endtask

  task automatic wait_idle(input int maxc, output int arv);
    int n;
    arv = 0; n = 0;
    while (busy && n < maxc) begin
      @(negedge tb_ACLK);
      if (M_AXI_ARVALID) arv++;
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic end_test(input string name);
    repeat (10) @(negedge tb_ACLK);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                busy, done, error, err_code, err_index});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int arv;
    logic [127:0] cfg1, cfg2, cfg4, cfg4b, cfg5, cfg6, junk;
    cfg1  = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101ffff};
    cfg2  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    cfg4  = {32'h0000000d, 32'h0000000c, 32'h0000000b, 32'h0000000a};
    cfg4b = {32'hcafe0004, 32'hcafe0003, 32'hcafe0002, 32'hcafe0001};
    cfg5  = {32'h55550004, 32'h55550003, 32'h55550002, 32'h55550001};
    cfg6  = {32'h66660004, 32'h66660003, 32'h66660002, 32'h66660001};
    junk  = {32'hffff0004, 32'hffff0003, 32'hffff0002, 32'hffff0001};
    ARESET = 1'b1; start = 1'b0; cfg_data = '0;
    repeat (3) @(posedge tb_ACLK);
    #1 chk("reset_outputs", outs_vec(), 32'd0);
    ARESET = 1'b0;
    repeat (2) @(posedge tb_ACLK);

    // 1: zero-wait slave, full pass; starts while busy and in DONE are ignored
    push_pass(cfg1, 25);
    do_start(cfg1);
    repeat (4) @(posedge tb_ACLK);
    pulse_start(junk);                       // cycle 5, busy
    repeat (19) @(posedge tb_ACLK);
    pulse_start(junk);                       // cycle 25, DONE
    wait_idle(100, arv);
    chk("t1_error", 32'(error), 32'd0);
    end_test("t1");

    // 2: AWREADY held low three cycles, W accepted first
    slv_aw_wait = 3;
    push_pass(cfg2, 28);
    do_start(cfg2);
    @(negedge tb_ACLK);
    chk("t2_c1_both_valid", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'b11);
    @(negedge tb_ACLK);
    chk("t2_c2_w_dropped_aw_held", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'b10);
    repeat (3) @(negedge tb_ACLK);
    chk("t2_c5_aw_dropped", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'b00);
    wait_idle(100, arv);
    end_test("t2");

    // 3: readback mismatch on register 2
    slv_bad_en = 1'b1; slv_bad_addr = 32'h8; slv_bad_val = 32'hdead0010;
    push_w(32'h0, cfg1[31:0]);   push_r(32'h0);
    push_w(32'h4, cfg1[63:32]);  push_r(32'h4);
    push_w(32'h8, cfg1[95:64]);  push_r(32'h8);
    push_d(1'b1, 2'b10, 3'd2, 19);
    do_start(cfg1);
    wait_idle(100, arv);
    end_test("t3");
    slv_bad_en = 1'b0;

    // 4: SLVERR-style BRESP on register 1, then a clean rerun
    slv_bresp_en = 1'b1; slv_bresp_addr = 32'h4;
    push_w(32'h0, cfg4[31:0]); push_r(32'h0);
    push_w(32'h4, cfg4[63:32]);
    push_d(1'b1, 2'b01, 3'd1, 11);
    do_start(cfg4);
    wait_idle(100, arv);
    end_test("t4a");
    slv_bresp_en = 1'b0;
    push_pass(cfg4b, 25);
    do_start(cfg4b);
    @(negedge tb_ACLK);
    chk("t4_error_cleared", 32'({error, err_code, err_index}), 32'd0);
    wait_idle(100, arv);
    end_test("t4b");

    // 5: ARREADY never asserted -> timeout in RA
    slv_ar_block = 1'b1;
    push_w(32'h0, cfg5[31:0]);
    push_d(1'b1, 2'b11, 3'd0, 1028);
    do_start(cfg5);
    wait_idle(3000, arv);
    chk("t5_arvalid_cycles", 32'(arv), 32'd1023);
    end_test("t5");
    slv_ar_block = 1'b0;

    // 6: reset during WB of register 2; start while busy ignored
    push_w(32'h0, cfg6[31:0]);  push_r(32'h0);
    push_w(32'h4, cfg6[63:32]); push_r(32'h4);
    push_w(32'h8, cfg6[95:64]);
    do_start(cfg6);
    repeat (4) @(posedge tb_ACLK);
    pulse_start(junk);                       // cycle 5, busy
    for (int n = 0; n < 40 && (cyc - start_cyc + 1) < 15; n++) @(negedge tb_ACLK);
    chk("t6_in_wb_reg2", 32'({M_AXI_BREADY, busy}), 32'b11);
    ARESET = 1'b1;
    @(posedge tb_ACLK); #1;
    chk("t6_reset_outputs", outs_vec(), 32'd0);
    ARESET = 1'b0;
    repeat (20) @(negedge tb_ACLK);
    chk("t6_stays_idle", 32'(busy), 32'd0);
    end_test("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
